// File: rtl/ysyx_22050078_wb_ctrl_pkg.sv
// Shared widths and source encoding for the writeback controller slice.
package ysyx_22050078_wb_ctrl_pkg;

  localparam int CPU_WIDTH = 64;
  localparam int REG_ADDRW = 5;
  localparam int REG_NUM   = 32;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/ysyx_22050078_wb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: req[0]=EXU, req[1]=LSU; a single pointer picks the winner on contention.
module ysyx_22050078_rr_arb2
  import ysyx_22050078_wb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  wb_src_e pri;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (pri == SRC_EXU) ? 2'b01 : 2'b10;
    end
  end

  // After any accepted transfer, the loser of this round gets priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri <= SRC_EXU;
    end else if (accept) begin
      pri <= gnt[0] ? SRC_LSU : SRC_EXU;
    end
  end

endmodule

// File: rtl/ysyx_22050078_wb_ctrl.sv
// Writeback controller: arbitrates EXU/LSU onto the RF write port through one register stage
// and tracks pending destination registers in a scoreboard for IDU hazard checks.
module ysyx_22050078_wb_ctrl
  import ysyx_22050078_wb_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDRW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rsv_valid,
  input  logic [ADDR_WIDTH-1:0]      rsv_addr,
  output logic                       rsv_ready,
  input  logic                       exu_valid,
  input  logic [ADDR_WIDTH-1:0]      exu_addr,
  input  logic [DATA_WIDTH-1:0]      exu_data,
  output logic                       exu_ready,
  input  logic                       lsu_valid,
  input  logic [ADDR_WIDTH-1:0]      lsu_addr,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  output logic                       lsu_ready,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  input  logic [ADDR_WIDTH-1:0]      chk_addr1,
  input  logic [ADDR_WIDTH-1:0]      chk_addr2,
  output logic                       chk_busy1,
  output logic                       chk_busy2,
  output logic [2**ADDR_WIDTH-1:0]   busy_vec,
  output logic                       err
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [1:0]            gnt;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wr_live;
  logic                  rsv_fire;
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_d;

  ysyx_22050078_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({lsu_valid, exu_valid}),
    .accept (xfer),
    .gnt    (gnt)
  );

  assign exu_ready = gnt[0];
  assign lsu_ready = gnt[1];
  assign xfer      = |gnt;
  assign sel_addr  = gnt[1] ? lsu_addr : exu_addr;
  assign sel_data  = gnt[1] ? lsu_data : exu_data;
  assign wr_live   = xfer && (sel_addr != '0);

  assign rsv_ready = !busy_q[rsv_addr] || (rsv_addr == '0);
  assign rsv_fire  = rsv_valid && rsv_ready && (rsv_addr != '0);
  assign chk_busy1 = busy_q[chk_addr1];
  assign chk_busy2 = busy_q[chk_addr2];
  assign busy_vec  = busy_q;

  // Clear rides on the registered write so a bit frees exactly when the RF updates.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen) begin
      busy_d[rf_waddr] = 1'b0;
    end
    if (rsv_fire) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      err      <= 1'b0;
    end else begin
      busy_q <= busy_d;
      rf_wen <= wr_live;
      if (wr_live) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
        if (!busy_q[sel_addr]) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050078_wb_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_ysyx_22050078_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ready;
  logic        exu_valid;
  logic [4:0]  exu_addr;
  logic [63:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_addr;
  logic [63:0] lsu_data;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic [31:0] busy_vec;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit [31:0] m_busy;
  bit        m_err;
  bit        m_last_lsu;
  bit        m_wen;
  bit [4:0]  m_waddr;
  bit [63:0] m_wdata;

  bit obs_e, obs_l, obs_rr, obs_c1;

  logic [4:0] t2_ea [3] = '{5'd3, 5'd10, 5'd12};
  logic [4:0] t2_la [3] = '{5'd4, 5'd11, 5'd13};

  ysyx_22050078_wb_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .exu_valid (exu_valid),
    .exu_addr  (exu_addr),
    .exu_data  (exu_data),
    .exu_ready (exu_ready),
    .lsu_valid (lsu_valid),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .busy_vec  (busy_vec),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy     = '0;
    m_err      = 1'b0;
    m_last_lsu = 1'b1;
    m_wen      = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
  endtask

  task automatic idle();
    rsv_valid = 1'b0; rsv_addr = '0;
    exu_valid = 1'b0; exu_addr = '0; exu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
  endtask

  // One clock: inputs are set at the negedge before the call; combinational outputs are
  // checked, the model advances across the posedge, registered outputs are checked at the next negedge.
  task automatic step();
    bit        want_e, want_l, want_rr;
    bit [4:0]  wa;
    bit [63:0] wd;
    bit [31:0] nb;
    bit        n_err, n_last, n_wen;
    #1;
    want_e  = exu_valid && (!lsu_valid || m_last_lsu);
    want_l  = lsu_valid && !want_e;
    want_rr = (rsv_addr == 0) || !m_busy[rsv_addr];
    check("exu_ready", exu_ready, want_e);
    check("lsu_ready", lsu_ready, want_l);
    check("rsv_ready", rsv_ready, want_rr);
    check("chk_busy1", chk_busy1, (chk_addr1 != 0) && m_busy[chk_addr1]);
    check("chk_busy2", chk_busy2, (chk_addr2 != 0) && m_busy[chk_addr2]);
    obs_e = exu_ready; obs_l = lsu_ready; obs_rr = rsv_ready; obs_c1 = chk_busy1;

    wa = want_e ? exu_addr : lsu_addr;
    wd = want_e ? exu_data : lsu_data;
    n_err  = m_err;
    n_last = m_last_lsu;
    if (want_e || want_l) begin
      n_last = want_l;
      if (wa != 0 && !m_busy[wa]) n_err = 1'b1;
    end
    nb = m_busy;
    if (m_wen) nb[m_waddr] = 1'b0;
    if (rsv_valid && want_rr && rsv_addr != 0) nb[rsv_addr] = 1'b1;
    n_wen = (want_e || want_l) && wa != 0;

    @(posedge clk);
    m_busy = nb; m_err = n_err; m_last_lsu = n_last; m_wen = n_wen;
    if (n_wen) begin
      m_waddr = wa; m_wdata = wd;
    end
    @(negedge clk);
    check("rf_wen", rf_wen, m_wen);
    if (m_wen) begin
      check("rf_waddr", rf_waddr, m_waddr);
      check("rf_wdata", rf_wdata, m_wdata);
    end
    check("busy_vec", busy_vec, m_busy);
    check("err", err, m_err);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic pick_addr(output logic [4:0] a);
    a = 5'($urandom_range(0, 7));
    for (int t = 0; t < 3; t++) begin
      if (a == 0 || m_busy[a]) break;
      a = 5'($urandom_range(0, 7));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    chk_addr1 = '0; chk_addr2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wen", rf_wen, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_busy", busy_vec, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // reserve then write x5
    rsv_valid = 1; rsv_addr = 5; step();
    idle(); exu_valid = 1; exu_addr = 5; exu_data = 64'h1234; step();
    check("t1_ready", obs_e, 1);
    check("t1_wen", rf_wen, 1);
    check("t1_data", rf_wdata, 64'h1234);
    idle(); step();
    check("t1_clear", busy_vec[5], 0);

    // contention from reset alternates E,L,E,L
    do_reset();
    foreach (t2_ea[i]) begin
      rsv_valid = 1; rsv_addr = t2_ea[i]; step();
      rsv_addr = t2_la[i]; step();
    end
    idle();
    exu_valid = 1; exu_addr = t2_ea[0]; exu_data = 64'hE0;
    lsu_valid = 1; lsu_addr = t2_la[0]; lsu_data = 64'hA0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_gnt", {obs_e, obs_l}, (i % 2 == 0) ? 2'b10 : 2'b01);
      check("t2_nobubble", rf_wen, 1);
      if (obs_e) begin exu_addr = t2_ea[i/2 + 1]; exu_data = 64'hE1 + 64'(i); end
      if (obs_l) begin lsu_addr = t2_la[i/2 + 1]; lsu_data = 64'hA1 + 64'(i); end
    end
    for (int i = 0; i < 3 && (exu_valid || lsu_valid); i++) begin
      if (obs_e) exu_valid = 0;
      if (obs_l) lsu_valid = 0;
      step();
    end
    idle(); step(); step();
    check("t2_err", err, 0);

    // WAW stall on busy x7
    rsv_valid = 1; rsv_addr = 7; step();
    chk_addr1 = 7; step();
    check("t3_stall", obs_rr, 0);
    check("t3_busy", obs_c1, 1);
    exu_valid = 1; exu_addr = 7; exu_data = 64'h77; step();
    exu_valid = 0; step();
    check("t3_still", obs_rr, 0);
    step();
    check("t3_free", obs_rr, 1);
    idle(); chk_addr1 = 0;
    exu_valid = 1; exu_addr = 7; exu_data = 64'h78; step();
    idle(); step();

    // write to x0 is dropped
    exu_valid = 1; exu_addr = 0; exu_data = 64'hFFFF; step();
    check("t4_ready", obs_e, 1);
    check("t4_wen", rf_wen, 0);
    check("t4_err", err, 0);
    idle(); step();

    // unreserved write sets sticky err
    lsu_valid = 1; lsu_addr = 9; lsu_data = 64'h99; step();
    check("t5_wen", rf_wen, 1);
    check("t5_err", err, 1);
    idle(); repeat (3) step();
    check("t5_sticky", err, 1);

    // async reset with reservations and a write in flight
    rsv_valid = 1; rsv_addr = 1; step();
    rsv_addr = 2; step();
    idle(); exu_valid = 1; exu_addr = 1; exu_data = 64'hDEAD;
    @(posedge clk);
    #1;
    check("t6_inflight", rf_wen, 1);
    #1;
    rst = 1'b1;
    idle();
    #1;
    check("t6_wen", rf_wen, 0);
    check("t6_waddr", rf_waddr, 0);
    check("t6_wdata", rf_wdata, 0);
    check("t6_busy", busy_vec, 0);
    check("t6_err", err, 0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) step();

    // randomized traffic; a source that was not granted holds its request
    for (int c = 0; c < 400; c++) begin
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = 5'($urandom_range(0, 7));
      chk_addr1 = 5'($urandom_range(0, 7));
      chk_addr2 = 5'($urandom_range(0, 31));
      if (!exu_valid || obs_e) begin
        exu_valid = ($urandom_range(0, 2) != 0);
        pick_addr(exu_addr);
        exu_data = {$urandom, $urandom};
      end
      if (!lsu_valid || obs_l) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        pick_addr(lsu_addr);
        lsu_data = {$urandom, $urandom};
      end
      obs_e = 0; obs_l = 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
